// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
// Used by imem_loader and word_packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts stream bytes into a big-endian 32-bit word.
// word/word_ready are valid in the cycle the final byte is accepted.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sh;
  logic [1:0]  idx;

  assign word       = {sh, byte_data};
  assign word_ready = shift && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sh  <= '0;
      idx <= '0;
    end else if (clear) begin
      sh  <= '0;
      idx <= '0;
    end else if (shift) begin
      sh  <= {sh[15:0], byte_data};
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a length-prefixed byte stream into instruction memory.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W:0] MAX_WORDS =
    {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = CHK;
`else
  localparam loader_state_t END_ST = DONE;
`endif

  loader_state_t     state;
  logic [7:0]        len_hi;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  word_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  len;
  logic              hs;
  logic              go;
  logic              word_ready;
  logic [31:0]       word;

  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA)   || (state == CHK);
  assign busy    = byte_ready;
  assign done    = (state == DONE);
  assign error   = (state == ERR);
  // Drop the clear only while the image is known good.
  assign cpu_clr = (state != DONE) || start;
  assign hs      = byte_valid && byte_ready;
  assign go      = start && !busy;
  assign len     = CNT_W'({len_hi, byte_data});

  word_packer u_packer (
    .clk        (clk),
    .clr_n      (clr_n),
    .clear      (go),
    .shift      (hs && (state == DATA)),
    .byte_data  (byte_data),
    .word       (word),
    .word_ready (word_ready)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      csum <= '0;
    end else if (go) begin
      csum <= '0;
    end else if (hs && (state != CHK)) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      len_hi   <= '0;
      count    <= '0;
      word_cnt <= '0;
      addr_cnt <= '0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_wen <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_HI;
            word_cnt <= '0;
            addr_cnt <= '0;
          end
        end
        LEN_HI: begin
          if (hs) begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (hs) begin
            count <= len;
            if (len == '0)
              state <= END_ST;
            else if ({1'b0, len} > MAX_WORDS)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (word_ready) begin
            mem_wen  <= 1'b1;
            mem_addr <= addr_cnt;
            mem_data <= word;
            addr_cnt <= addr_cnt + 1'b1;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt + 1'b1 == count)
              state <= END_ST;
          end
        end
        CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (hs)
            state <= (byte_data == csum) ? DONE : ERR;
`else
          state <= ERR;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction memory: accepts a byte stream, packs it into 32-bit big-endian instruction words and writes them into the memory_unit at sequential word addresses.
- Holds the processor datapath in clear until a complete image is loaded, then releases it so execution starts from word address 0.
- Sits between an external byte source (UART receiver, bench) and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- mem_wen  output  1  instruction memory write enable, one-cycle pulse
- mem_addr  output  ADDR_W  word address being written
- mem_data  output  32  instruction word being written
- cpu_clr  output  1  active-high clear to the processor datapath
- busy  output  1  load in progress
- done  output  1  sticky: load completed successfully
- error  output  1  sticky: load aborted

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE; byte_ready=0, mem_wen=0, mem_addr=0, mem_data=0.
  - cpu_clr=1, busy=0, done=0, error=0.
- Handshake: a byte transfers on a rising clk edge when byte_valid && byte_ready. byte_ready is 1 in LEN_HI, LEN_LO, DATA and CHK, and 0 elsewhere.
- Stream format: count[15:8], count[7:0], then count words of 4 bytes each, MSB first.
- IDLE:
  - cpu_clr=1.
  - start -> LEN_HI; clears done and error; zeroes the byte index, address counter and word counter.
- LEN_HI: byte accepted -> store count[15:8] -> LEN_LO.
- LEN_LO: byte accepted -> store count[7:0], then:
  - count==0 -> DONE (or CHK when the feature is enabled).
  - count > 2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA:
  - Bytes shift into a 32-bit assembly register; byte index 0..3 wraps.
  - On the 4th byte, the next cycle drives mem_wen=1, mem_addr=word counter, mem_data=assembled word. Write latency is 1 cycle after the 4th handshake.
  - byte_ready stays 1 during the write cycle; the next word's first byte may be accepted simultaneously without corruption.
  - After the write, the word counter increments. Reaching count -> DONE (or CHK).
- DONE: cpu_clr=0, done=1, busy=0. start -> new load: cpu_clr returns to 1 in the same cycle start is sampled.
- ERR: cpu_clr=1, error=1, busy=0. Only start or reset leaves ERR.
- start while busy: ignored.
- byte_valid while byte_ready=0: ignored, nothing is consumed.
- busy=1 in LEN_HI, LEN_LO, DATA and CHK.
- Reset mid-load: returns to IDLE immediately. Partially written memory is left as is; cpu_clr is 1.
- mem_addr wraps to 0 only after the final word. A full 2**ADDR_W-word image is legal.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With it:
  - A running XOR of all header and payload bytes is kept.
  - After the last word, state CHK accepts one byte.
  - Byte equal to the running XOR -> DONE; mismatch -> ERR.
  - The last word's write still occurs before the check.
- Without it: there is no CHK state and no trailing byte; the last write goes straight to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - typedef enum logic [2:0] loader_state_t {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR};
  - localparam BYTES_PER_WORD = 4.
- Sub-module word_packer: byte shift register plus 2-bit index, with a word_ready pulse output. The FSM, counters and checksum stay in imem_loader.

Test Plan:
- Reset then idle: start never pulsed -> cpu_clr=1, byte_ready=0, mem_wen stays 0 for 20 cycles.
- Load 2 words: start; bytes 00 02 8C 08 00 04 AC 09 00 08 -> writes addr0=0x8C080004 and addr1=0xAC090008. Each mem_wen is 1 cycle after its 4th byte; then done=1, cpu_clr=0.
- Back-pressure/gaps: same stream with byte_valid toggled every other cycle -> identical writes. An invalid byte presented in DONE is not consumed.
- Zero count: start; bytes 00 00 -> no mem_wen, done=1 two handshakes after start.
- Oversize count: bytes 01 01 (257 > 256) -> error=1, cpu_clr=1, no writes. Then start with a valid 1-word stream -> done=1, error=0.
- Reset mid-load: clr_n low after 6 bytes -> immediate IDLE, cpu_clr=1, mem_wen=0. With IMEM_LOADER_CHECKSUM_EN: stream 00 01 12 34 56 78 with checksum 0x09 -> done; checksum 0x00 -> error.
